// File: rtl/vc_input_unit.sv
// Per-port NoC router input unit: one first-word-fall-through FIFO per virtual channel,
// a per-VC packet state machine, credit reporting and sticky error flags.
module vc_input_unit #(
    parameter int DEPTH            = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int VIRTUAL_CHANNELS = 2,
    parameter int NUM_PORTS        = 7,
    parameter int NOC_WIDTH        = 4,
    parameter int NOC_DEPTH        = 4,
    parameter int NOC_HEIGHT       = 4,
    localparam int VC_BITS       = (VIRTUAL_CHANNELS > 1) ? $clog2(VIRTUAL_CHANNELS) : 1,
    localparam int PORT_BITS     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int NOC_ADDR_BITS = $clog2(NOC_WIDTH) + $clog2(NOC_DEPTH) + $clog2(NOC_HEIGHT),
    localparam int DEPTH_BITS    = $clog2(DEPTH)
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            push,
    input  logic [VC_BITS-1:0]                              push_vc,
    input  logic [DATA_WIDTH-1:0]                           flit_in,
    output logic [VIRTUAL_CHANNELS-1:0]                     need_route,
    output logic [VIRTUAL_CHANNELS-1:0][NOC_ADDR_BITS-1:0]  dest_addr,
    input  logic                                            route_valid,
    input  logic [VC_BITS-1:0]                              route_vc,
    input  logic [PORT_BITS-1:0]                            route_in,
    output logic [VIRTUAL_CHANNELS-1:0]                     need_vc,
    input  logic                                            vc_grant,
    input  logic [VC_BITS-1:0]                              vc_grant_vc,
    input  logic [VC_BITS-1:0]                              vc_grant_out,
    output logic [VIRTUAL_CHANNELS-1:0]                     active,
    input  logic                                            pop,
    input  logic [VC_BITS-1:0]                              pop_vc,
    output logic [DATA_WIDTH-1:0]                           flit_out,
    output logic [PORT_BITS-1:0]                            route_out,
    output logic [VC_BITS-1:0]                              vc_out,
    output logic [VIRTUAL_CHANNELS-1:0][DEPTH_BITS:0]       credits,
    output logic                                            overflow_err,
    output logic                                            protocol_err
);

    localparam logic [DEPTH_BITS:0] DEPTH_FULL = (DEPTH_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUTING,
        ST_VC_ALLOC,
        ST_ACTIVE
    } vc_state_t;

    vc_state_t                 state_q [VIRTUAL_CHANNELS];
    vc_state_t                 state_d [VIRTUAL_CHANNELS];
    logic [DATA_WIDTH-1:0]     mem     [VIRTUAL_CHANNELS][DEPTH];
    logic [DATA_WIDTH-1:0]     front   [VIRTUAL_CHANNELS];
    logic [DEPTH_BITS-1:0]     wr_ptr  [VIRTUAL_CHANNELS];
    logic [DEPTH_BITS-1:0]     rd_ptr  [VIRTUAL_CHANNELS];
    logic [DEPTH_BITS:0]       count   [VIRTUAL_CHANNELS];
    logic [PORT_BITS-1:0]      route_q [VIRTUAL_CHANNELS];
    logic [VC_BITS-1:0]        outvc_q [VIRTUAL_CHANNELS];

    logic [VIRTUAL_CHANNELS-1:0] started_q;
    logic [VIRTUAL_CHANNELS-1:0] started_d;
    logic [VIRTUAL_CHANNELS-1:0] do_push;
    logic [VIRTUAL_CHANNELS-1:0] do_deq;
    logic [VIRTUAL_CHANNELS-1:0] proto_hit;
    logic [VIRTUAL_CHANNELS-1:0] latch_route;
    logic [VIRTUAL_CHANNELS-1:0] latch_vc;
    logic                        push_vc_ok;
    logic                        push_drop;

    function automatic logic [DEPTH_BITS-1:0] ptr_next(input logic [DEPTH_BITS-1:0] p);
        return (p == DEPTH_BITS'(DEPTH - 1)) ? '0 : p + DEPTH_BITS'(1);
    endfunction

    always_comb begin
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            front[v] = mem[v][rd_ptr[v]];
        end
    end

    // started_q marks that the head of the current packet has already left, so a later
    // head-typed flit in the same packet is a protocol violation.
    always_comb begin
        push_vc_ok = int'(push_vc) < VIRTUAL_CHANNELS;
        push_drop  = push && !push_vc_ok;
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            state_d[v]     = state_q[v];
            started_d[v]   = started_q[v];
            do_deq[v]      = 1'b0;
            proto_hit[v]   = 1'b0;
            latch_route[v] = 1'b0;
            latch_vc[v]    = 1'b0;
            case (state_q[v])
                ST_IDLE: begin
                    if (count[v] != '0) begin
                        if (front[v][DATA_WIDTH-2]) begin
                            state_d[v] = ST_ROUTING;
                        end else begin
                            do_deq[v]    = 1'b1;
                            proto_hit[v] = 1'b1;
                        end
                    end
                end
                ST_ROUTING: begin
                    if (route_valid && route_vc == VC_BITS'(v)) begin
                        state_d[v]     = ST_VC_ALLOC;
                        latch_route[v] = 1'b1;
                    end
                end
                ST_VC_ALLOC: begin
                    if (vc_grant && vc_grant_vc == VC_BITS'(v)) begin
                        state_d[v]   = ST_ACTIVE;
                        latch_vc[v]  = 1'b1;
                        started_d[v] = 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (pop && pop_vc == VC_BITS'(v) && count[v] != '0) begin
                        do_deq[v]    = 1'b1;
                        started_d[v] = 1'b1;
                        if (front[v][DATA_WIDTH-2] && started_q[v]) begin
                            proto_hit[v] = 1'b1;
                        end
                        if (front[v][DATA_WIDTH-1]) begin
                            state_d[v]   = ST_IDLE;
                            started_d[v] = 1'b0;
                        end
                    end
                end
                default: state_d[v] = ST_IDLE;
            endcase
            do_push[v] = push && push_vc == VC_BITS'(v) && (count[v] != DEPTH_FULL || do_deq[v]);
            if (push && push_vc == VC_BITS'(v) && !do_push[v]) begin
                push_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                state_q[v] <= ST_IDLE;
                wr_ptr[v]  <= '0;
                rd_ptr[v]  <= '0;
                count[v]   <= '0;
                route_q[v] <= '0;
                outvc_q[v] <= '0;
            end
            started_q    <= '0;
            overflow_err <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                state_q[v] <= state_d[v];
                if (do_push[v]) begin
                    wr_ptr[v] <= ptr_next(wr_ptr[v]);
                end
                if (do_deq[v]) begin
                    rd_ptr[v] <= ptr_next(rd_ptr[v]);
                end
                if (do_push[v] && !do_deq[v]) begin
                    count[v] <= count[v] + 1'b1;
                end else if (!do_push[v] && do_deq[v]) begin
                    count[v] <= count[v] - 1'b1;
                end
                if (latch_route[v]) begin
                    route_q[v] <= route_in;
                end
                if (latch_vc[v]) begin
                    outvc_q[v] <= vc_grant_out;
                end
            end
            started_q <= started_d;
            if (push_drop) begin
                overflow_err <= 1'b1;
            end
            if (|proto_hit) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // Flit storage carries no reset; contents are only observed behind a non-zero count.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            if (do_push[v]) begin
                mem[v][wr_ptr[v]] <= flit_in;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            need_route[v] = state_q[v] == ST_ROUTING;
            need_vc[v]    = state_q[v] == ST_VC_ALLOC;
            active[v]     = state_q[v] == ST_ACTIVE && count[v] != '0;
            dest_addr[v]  = front[v][NOC_ADDR_BITS-1:0];
            credits[v]    = DEPTH_FULL - count[v];
        end
    end

    always_comb begin
        flit_out  = front[0];
        route_out = route_q[0];
        vc_out    = outvc_q[0];
        for (int v = 1; v < VIRTUAL_CHANNELS; v++) begin
            if (pop_vc == VC_BITS'(v)) begin
                flit_out  = front[v];
                route_out = route_q[v];
                vc_out    = outvc_q[v];
            end
        end
    end

endmodule

// File: tb/tb_vc_input_unit.sv
// Bench for vc_input_unit: directed scenarios plus randomized well-formed packet traffic,
// checked against per-VC flit queues that play the role of the expected buffer contents.
module tb_vc_input_unit;

    localparam int DEPTH     = 4;
    localparam int DW        = 32;
    localparam int VCN       = 2;
    localparam int NUM_PORTS = 7;
    localparam int VCB       = 1;
    localparam int PB        = 3;
    localparam int AB        = 6;
    localparam int DB        = 2;

    logic                       clk;
    logic                       reset;
    logic                       push;
    logic [VCB-1:0]             push_vc;
    logic [DW-1:0]              flit_in;
    logic [VCN-1:0]             need_route;
    logic [VCN-1:0][AB-1:0]     dest_addr;
    logic                       route_valid;
    logic [VCB-1:0]             route_vc;
    logic [PB-1:0]              route_in;
    logic [VCN-1:0]             need_vc;
    logic                       vc_grant;
    logic [VCB-1:0]             vc_grant_vc;
    logic [VCB-1:0]             vc_grant_out;
    logic [VCN-1:0]             active;
    logic                       pop;
    logic [VCB-1:0]             pop_vc;
    logic [DW-1:0]              flit_out;
    logic [PB-1:0]              route_out;
    logic [VCB-1:0]             vc_out;
    logic [VCN-1:0][DB:0]       credits;
    logic                       overflow_err;
    logic                       protocol_err;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0]  mq [VCN][$];
    logic [PB-1:0]  exp_route [VCN];
    logic [VCB-1:0] exp_vcout [VCN];
    int             pkt_left  [VCN];
    int             pops_done [VCN];

    vc_input_unit dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_vc      (push_vc),
        .flit_in      (flit_in),
        .need_route   (need_route),
        .dest_addr    (dest_addr),
        .route_valid  (route_valid),
        .route_vc     (route_vc),
        .route_in     (route_in),
        .need_vc      (need_vc),
        .vc_grant     (vc_grant),
        .vc_grant_vc  (vc_grant_vc),
        .vc_grant_out (vc_grant_out),
        .active       (active),
        .pop          (pop),
        .pop_vc       (pop_vc),
        .flit_out     (flit_out),
        .route_out    (route_out),
        .vc_out       (vc_out),
        .credits      (credits),
        .overflow_err (overflow_err),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        push         = 1'b0;
        push_vc      = '0;
        flit_in      = '0;
        route_valid  = 1'b0;
        route_vc     = '0;
        route_in     = '0;
        vc_grant     = 1'b0;
        vc_grant_vc  = '0;
        vc_grant_out = '0;
        pop          = 1'b0;
        pop_vc       = '0;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int v = 0; v < VCN; v++) begin
            mq[v].delete();
            pkt_left[v]  = 0;
            pops_done[v] = 0;
        end
    endtask

    // Next flit of the packet being generated for VC v; new packets are 1-4 flits long.
    task automatic gen_flit(input int v, output logic [DW-1:0] f);
        logic [1:0] t;
        int len;
        if (pkt_left[v] == 0) begin
            len = $urandom_range(1, 4);
            pkt_left[v] = len;
            t = (len == 1) ? 2'b11 : 2'b01;
        end else begin
            t = (pkt_left[v] == 1) ? 2'b10 : 2'b00;
        end
        pkt_left[v]--;
        f = {t, 30'($urandom)};
    endtask

    // One clock cycle: the bench acts as route computation, VC allocator and switch
    // allocator, answering requests immediately and checking popped data against the queues.
    task automatic apply_stimulus(input logic do_push, input logic [VCB-1:0] pvc,
                                  input logic [DW-1:0] pflit, input logic pop_en);
        int  pv;
        int  start;
        int  w;
        logic accepted;
        clear_inputs();
        push    = do_push;
        push_vc = pvc;
        flit_in = pflit;
        for (int v = 0; v < VCN; v++) begin
            if (need_route[v] && !route_valid) begin
                route_valid  = 1'b1;
                route_vc     = VCB'(v);
                route_in     = PB'($urandom_range(0, NUM_PORTS - 1));
                exp_route[v] = route_in;
                check_output("route_req_nonempty", 64'(mq[v].size() > 0), 64'd1);
                if (mq[v].size() > 0) begin
                    check_output("route_req_head", 64'(mq[v][0][30]), 64'd1);
                    check_output("dest_addr", 64'(dest_addr[v]), 64'(mq[v][0][AB-1:0]));
                end
            end
            if (need_vc[v] && !vc_grant) begin
                vc_grant     = 1'b1;
                vc_grant_vc  = VCB'(v);
                vc_grant_out = VCB'($urandom_range(0, VCN - 1));
                exp_vcout[v] = vc_grant_out;
            end
        end
        pv = -1;
        if (pop_en) begin
            start = $urandom_range(0, VCN - 1);
            for (int i = 0; i < VCN; i++) begin
                w = (start + i) % VCN;
                if (active[w] && pv < 0) pv = w;
            end
            if (pv >= 0) begin
                pop    = 1'b1;
                pop_vc = VCB'(pv);
            end
        end
        #1;
        if (pv >= 0) begin
            check_output("pop_nonempty", 64'(mq[pv].size() > 0), 64'd1);
            if (mq[pv].size() > 0) begin
                check_output($sformatf("flit_out_vc%0d", pv), 64'(flit_out), 64'(mq[pv][0]));
                check_output($sformatf("route_out_vc%0d", pv), 64'(route_out), 64'(exp_route[pv]));
                check_output($sformatf("vc_out_vc%0d", pv), 64'(vc_out), 64'(exp_vcout[pv]));
            end
        end
        accepted = do_push && (mq[pvc].size() < DEPTH);
        tick();
        if (pv >= 0 && mq[pv].size() > 0) begin
            void'(mq[pv].pop_front());
            pops_done[pv]++;
        end
        if (accepted) mq[pvc].push_back(pflit);
        for (int v = 0; v < VCN; v++) begin
            check_output($sformatf("credits_vc%0d", v), 64'(credits[v]), 64'(DEPTH - mq[v].size()));
        end
    endtask

    function automatic bit model_empty();
        bit e;
        e = 1'b1;
        for (int v = 0; v < VCN; v++) begin
            if (mq[v].size() != 0 || pkt_left[v] != 0) e = 1'b0;
        end
        return e;
    endfunction

    initial begin
        logic [DW-1:0]  il_flit [6];
        int             il_vc   [6];
        logic           dp;
        logic [VCB-1:0] pvc;
        logic [DW-1:0]  f;
        int             rv;
        bit             done;

        clear_inputs();
        clear_model();
        reset = 1'b1;
        #2;
        check_output("rst_credits0", 64'(credits[0]), 64'd4);
        check_output("rst_credits1", 64'(credits[1]), 64'd4);
        check_output("rst_status", 64'({need_route, need_vc, active}), 64'd0);
        check_output("rst_errs", 64'({overflow_err, protocol_err}), 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // Single-flit packet latency on VC1
        push = 1'b1; push_vc = 1'b1; flit_in = 32'hC000_0015;
        tick();
        clear_inputs();
        #1;
        check_output("lat_c1_need_route", 64'(need_route[1]), 64'd0);
        tick();
        check_output("lat_c2_need_route", 64'(need_route[1]), 64'd1);
        check_output("lat_c2_dest", 64'(dest_addr[1]), 64'h15);
        route_valid = 1'b1; route_vc = 1'b1; route_in = 3'd5;
        tick();
        clear_inputs();
        #1;
        check_output("lat_c3_need_vc", 64'(need_vc[1]), 64'd1);
        check_output("lat_c3_need_route", 64'(need_route[1]), 64'd0);
        vc_grant = 1'b1; vc_grant_vc = 1'b1; vc_grant_out = 1'b1;
        tick();
        clear_inputs();
        #1;
        check_output("lat_c4_active", 64'(active[1]), 64'd1);
        check_output("lat_c4_credits", 64'(credits[1]), 64'd3);
        pop = 1'b1; pop_vc = 1'b1;
        #1;
        check_output("lat_c4_flit", 64'(flit_out), 64'hC000_0015);
        check_output("lat_c4_vc_out", 64'(vc_out), 64'd1);
        check_output("lat_c4_route_out", 64'(route_out), 64'd5);
        tick();
        clear_inputs();
        #1;
        check_output("lat_c5_idle", 64'({need_route[1], need_vc[1], active[1]}), 64'd0);
        check_output("lat_c5_credits", 64'(credits[1]), 64'd4);

        // Interleaved packets: 4 flits on VC0, 2 flits on VC1
        il_flit[0] = 32'h4000_0A01; il_vc[0] = 0;
        il_flit[1] = 32'h4000_0D05; il_vc[1] = 1;
        il_flit[2] = 32'h0000_0B02; il_vc[2] = 0;
        il_flit[3] = 32'h8000_0E06; il_vc[3] = 1;
        il_flit[4] = 32'h0000_0B03; il_vc[4] = 0;
        il_flit[5] = 32'h8000_0C04; il_vc[5] = 0;
        clear_model();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, VCB'(il_vc[i]), il_flit[i], 1'b1);
        end
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            apply_stimulus(1'b0, '0, '0, 1'b1);
            done = model_empty();
        end
        check_output("il_drained", 64'(done), 64'd1);
        check_output("il_pops_vc0", 64'(pops_done[0]), 64'd4);
        check_output("il_pops_vc1", 64'(pops_done[1]), 64'd2);

        // Simultaneous push and pop on an ACTIVE VC holding two flits
        apply_stimulus(1'b1, 1'b0, 32'h4000_1111, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0000_2222, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0000_3333, 1'b0);
        for (int c = 0; c < 10 && !active[0]; c++) begin
            apply_stimulus(1'b0, '0, '0, 1'b0);
        end
        check_output("sp_active", 64'(active[0]), 64'd1);
        apply_stimulus(1'b0, '0, '0, 1'b1);
        check_output("sp_credits_two", 64'(credits[0]), 64'd2);
        apply_stimulus(1'b1, 1'b0, 32'h0000_4444, 1'b1);
        check_output("sp_credits_same", 64'(credits[0]), 64'd2);
        apply_stimulus(1'b1, 1'b0, 32'h8000_5555, 1'b1);
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            apply_stimulus(1'b0, '0, '0, 1'b1);
            done = model_empty();
        end
        check_output("sp_drained", 64'(done), 64'd1);

        // Overflow: fifth flit into a four-deep VC with no pops
        apply_stimulus(1'b1, 1'b0, 32'h4000_00A0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0000_00A1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0000_00A2, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0000_00A3, 1'b0);
        check_output("ovf_before", 64'(overflow_err), 64'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0000_00A4, 1'b0);
        check_output("ovf_flag", 64'(overflow_err), 64'd1);
        check_output("ovf_credits0", 64'(credits[0]), 64'd0);
        check_output("ovf_credits1", 64'(credits[1]), 64'd4);
        check_output("ovf_vc1_status", 64'({need_route[1], need_vc[1], active[1]}), 64'd0);

        // Reset asserted mid-cycle with a full VC
        #2;
        reset = 1'b1;
        #1;
        check_output("mrst_credits0", 64'(credits[0]), 64'd4);
        check_output("mrst_credits1", 64'(credits[1]), 64'd4);
        check_output("mrst_status", 64'({need_route, need_vc, active}), 64'd0);
        check_output("mrst_errs", 64'({overflow_err, protocol_err}), 64'd0);
        clear_model();
        tick();
        reset = 1'b0;

        // Body flit arriving at an IDLE VC
        clear_inputs();
        push = 1'b1; push_vc = 1'b0; flit_in = 32'h0000_0001;
        tick();
        clear_inputs();
        #1;
        check_output("pe_credits_held", 64'(credits[0]), 64'd3);
        check_output("pe_flag_before", 64'(protocol_err), 64'd0);
        tick();
        check_output("pe_credits_back", 64'(credits[0]), 64'd4);
        check_output("pe_flag", 64'(protocol_err), 64'd1);
        check_output("pe_need_route", 64'(need_route[0]), 64'd0);
        tick();
        check_output("pe_need_route_later", 64'(need_route[0]), 64'd0);

        // Randomized well-formed traffic on both VCs
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        for (int c = 0; c < 300; c++) begin
            rv  = $urandom_range(0, VCN - 1);
            pvc = VCB'(rv);
            dp  = 1'b0;
            f   = '0;
            if ($urandom_range(0, 9) < 6 && mq[rv].size() < DEPTH) begin
                gen_flit(rv, f);
                dp = 1'b1;
            end
            apply_stimulus(dp, pvc, f, $urandom_range(0, 9) < 7);
        end
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            dp  = 1'b0;
            f   = '0;
            pvc = '0;
            for (int v = 0; v < VCN; v++) begin
                if (!dp && pkt_left[v] > 0 && mq[v].size() < DEPTH) begin
                    gen_flit(v, f);
                    pvc = VCB'(v);
                    dp  = 1'b1;
                end
            end
            apply_stimulus(dp, pvc, f, 1'b1);
            done = model_empty();
        end
        check_output("rnd_drained", 64'(done), 64'd1);
        check_output("rnd_errs", 64'({overflow_err, protocol_err}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
